wave_scope_capture: RTL and testbench
=====================================

WAVE_SCOPE_CAPTURE -- requirements
Module: wave_scope_capture

Interface
REQ-001 Parameter NUM_CH, default 2: number of audio channels captured and drawn.
REQ-002 Parameter SAMPLE_W, default 16: signed two's-complement sample width, at least 9.
REQ-003 Parameter DEPTH, default 1024: samples per channel per bank, a power of two; ADDR_W = log2(DEPTH).
REQ-004 MTL_CLK  in  1  sole clock; all logic and both RAM ports run on its rising edge.
REQ-005 RESET_n  in  1  asynchronous, active-low reset.
REQ-006 SAMPLE_TR  in  1  one-cycle sample strobe, synchronous to MTL_CLK.
REQ-007 WAVE  in  NUM_CH*SAMPLE_W  packed samples; channel k occupies bits [k*SAMPLE_W +: SAMPLE_W].
REQ-008 SCAL  in  3  decimation: one sample is kept per SCAL+1 strobes.
REQ-009 START_STOP  in  1  1 = run; 0 = freeze the displayed bank.
REQ-010 TRIG_EN  in  1  1 = wait for a channel-0 rising-level trigger; 0 = free-run.
REQ-011 TRIG_LEVEL  in  SAMPLE_W  signed trigger threshold.
REQ-012 FRAME_SYNC  in  1  display vertical sync, level, active-high.
REQ-013 DRAW_DOT  in  1  1 = dot mode; 0 = line mode.
REQ-014 H_CNT, V_CNT  in  12 each  display scan counters.
REQ-015 PIX_RGB  out  24  pixel colour, registered.
REQ-016 CAPT_STATE  out  2  current state encoding.
REQ-017 BANK_SEL  out  1  index of the bank being written.

Function
REQ-018 Decimation counter dc advances only on SAMPLE_TR, counting 0..SCAL and wrapping to 0; a strobe is accepted only when dc==0; a SCAL change takes effect at the next wrap.
REQ-019 State machine: ARM(0), CAPTURE(1), FULL(2); the encoding is 3 and never occurs.
REQ-020 ARM, TRIG_EN=0: the first accepted strobe writes address 0 and the state moves to CAPTURE.
REQ-021 ARM, TRIG_EN=1: channel 0 is registered on every accepted strobe; a trigger is an accepted sample with prev<TRIG_LEVEL and cur>=TRIG_LEVEL (signed); that sample writes address 0.
REQ-022 The first accepted strobe after entering ARM only primes prev and can never trigger.
REQ-023 CAPTURE: each accepted strobe writes all NUM_CH samples to address wa in the write bank, then increments wa.
REQ-024 The write at wa==DEPTH-1 moves the state to FULL; no further writes occur until the next ARM.
REQ-025 FULL: the FRAME_SYNC rising edge (registered 0 followed by 1) with START_STOP=1 toggles BANK_SEL, clears wa and moves the state to ARM, all in the same cycle.
REQ-026 FULL with START_STOP=0 holds indefinitely; the display bank remains frozen.
REQ-027 START_STOP is sampled only at the swap point; capture already in progress continues to FULL.
REQ-028 If a FRAME_SYNC edge and an accepted strobe coincide in FULL, the swap wins and the strobe is discarded.
REQ-029 Read port: address = H_CNT[ADDR_W-1:0] on the bank ~BANK_SEL; data is available 1 cycle later.
REQ-030 Pixels with H_CNT>=DEPTH draw no trace.
REQ-031 Per channel, Y = {~s[SAMPLE_W-1], s[SAMPLE_W-2 -: 8]} (9 bits).
REQ-032 The pipeline keeps Y(n) and Y(n+1) for consecutive H_CNT.
REQ-033 Dot mode hits when V_CNT[8:0]==Y(n).
REQ-034 Line mode hits when V_CNT[8:0] lies in [min, max) of Y(n) and Y(n+1), or equals Y(n) when the two are equal.
REQ-035 Colour priority: the lowest-index channel hit takes CH_COLOR[k]; otherwise V_CNT[8:0]==255 gives 24'h6F6F6F when START_STOP=1 or 24'hFF0000 when 0; otherwise 0.
REQ-036 PIX_RGB latency is 3 MTL_CLK cycles from H_CNT/V_CNT (RAM read, pair register, colour register); V_CNT is delayed to match.

Reset
REQ-037 RESET_n low forces state ARM, BANK_SEL=0, wa=0, dc=0, prev=0, registered FRAME_SYNC=0 and PIX_RGB=0.
REQ-038 RAM contents are undefined after reset.
REQ-039 Reset mid-CAPTURE abandons the partial capture; the first post-reset frame displays bank 1, contents undefined.
REQ-040 Deassertion is applied directly to the flops; synchronisation is external.

Structure
REQ-041 Shared package wave_scope_pkg holds the state enum, CH_COLOR table (ch0 24'hFFFF00, ch1 24'h00FFFF, ch2 24'hFF00FF, ch3 24'h00FF00), GRID_COLOR, STOP_COLOR and CENTRE_ROW=255.
REQ-042 Sub-module wave_pingpong_ram holds 2 banks of DEPTH x (NUM_CH*SAMPLE_W) simple dual-port memory with a registered read; the bank bit is the address MSB.

Verification
REQ-043 Decimation: SCAL=3, 16 strobes in ARM with TRIG_EN=0 -> exactly 4 writes, at addresses 0..3.
REQ-044 Trigger: TRIG_EN=1, TRIG_LEVEL=0, ch0 ramp -8,-4,0,4 -> address 0 holds 0; nothing is written before it.
REQ-045 Fill/swap: DEPTH=16, 16 accepted samples -> FULL; the next FRAME_SYNC rise toggles BANK_SEL to 1 and the state becomes ARM.
REQ-046 Freeze: START_STOP=0 in FULL across 3 frames -> BANK_SEL is unchanged; centre row pixel = 24'hFF0000.
REQ-047 Pixel: ch0 samples 16'h0000, 16'h0100 at H 5,6, line mode -> Y 256 and 258; V=256,257 give 24'hFFFF00 and V=258 gives 0, 3 cycles after H_CNT.
REQ-048 Reset asserted mid-CAPTURE at wa=7 -> state ARM, wa=0, PIX_RGB=0 immediately, without a clock edge.

Source files
------------

// File: rtl/wave_scope_pkg.sv
// Shared types and display constants for the oscilloscope capture block.
package wave_scope_pkg;

    // The fourth encoding (2'd3) is unreachable and recovers to ST_ARM.
    typedef enum logic [1:0] {
        ST_ARM     = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FULL    = 2'd2
    } capt_state_t;

    localparam logic [23:0] CH_COLOR [4] = '{24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'h00FF00};
    localparam logic [23:0] GRID_COLOR   = 24'h6F6F6F;
    localparam logic [23:0] STOP_COLOR   = 24'hFF0000;
    localparam logic [8:0]  CENTRE_ROW   = 9'd255;

    // Trace colour for a channel; the table repeats beyond four channels.
    function automatic logic [23:0] ch_color(input logic [1:0] k);
        return CH_COLOR[k];
    endfunction

endpackage

// File: rtl/wave_pingpong_ram.sv
// Two-bank sample store: the bank bit is the address MSB, so the capture side
// fills one bank while the display side reads the other.
module wave_pingpong_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W:0]   i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W:0]   i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**(ADDR_W+1)];
    logic [DATA_W-1:0] r_rdata;

    // Write port and registered read port; contents are not reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/wave_scope_capture.sv
// Audio oscilloscope: decimated, optionally triggered capture into a ping-pong
// RAM, and a 3-cycle pixel pipeline drawing the frozen bank as traces.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_ARM     | waiting for first accepted strobe (free-run) or trigger
// ST_CAPTURE | writing one sample set per accepted strobe into write bank
// ST_FULL    | bank full; swap on FRAME_SYNC rise when START_STOP=1
module wave_scope_capture
    import wave_scope_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 16,
    parameter int DEPTH    = 1024
) (
    input  logic                         i_mtl_clk,
    input  logic                         i_reset_n,
    input  logic                         i_sample_tr,
    input  logic [NUM_CH*SAMPLE_W-1:0]   i_wave,
    input  logic [2:0]                   i_scal,
    input  logic                         i_start_stop,
    input  logic                         i_trig_en,
    input  logic signed [SAMPLE_W-1:0]   i_trig_level,
    input  logic                         i_frame_sync,
    input  logic                         i_draw_dot,
    input  logic [11:0]                  i_h_cnt,
    input  logic [11:0]                  i_v_cnt,
    output logic [23:0]                  o_pix_rgb,
    output logic [1:0]                   o_capt_state,
    output logic                         o_bank_sel
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int DATA_W = NUM_CH * SAMPLE_W;

    logic [2:0]                 r_dc;
    logic [2:0]                 r_scal;
    capt_state_t                r_state;
    logic [ADDR_W-1:0]          r_wa;
    logic                       r_bank;
    logic                       r_fs_q;
    logic                       r_primed;
    logic signed [SAMPLE_W-1:0] r_prev;

    logic                       w_acc;
    logic signed [SAMPLE_W-1:0] w_ch0;
    logic                       w_trig;
    logic                       w_fs_rise;
    logic                       w_we;
    logic [ADDR_W:0]            w_waddr;
    logic [DATA_W-1:0]          w_wdata;
    logic [DATA_W-1:0]          w_rdata;

    logic                       r_hv1, r_hv2;
    logic [8:0]                 r_v1, r_v2;
    logic [8:0]                 r_y_n  [NUM_CH];
    logic [8:0]                 r_y_n1 [NUM_CH];
    logic [NUM_CH-1:0]          w_hit;
    logic [23:0]                w_pix;
    logic [23:0]                r_pix;
    logic                       w_unused;

    assign w_acc     = i_sample_tr && (r_dc == 3'd0);
    assign w_ch0     = i_wave[SAMPLE_W-1:0];
    assign w_trig    = r_primed && (r_prev < i_trig_level) && (w_ch0 >= i_trig_level);
    assign w_fs_rise = i_frame_sync && !r_fs_q;
    assign w_we      = w_acc && (((r_state == ST_ARM) && (!i_trig_en || w_trig)) ||
                                 (r_state == ST_CAPTURE));
    assign w_waddr   = {r_bank, r_wa};
    assign w_wdata   = i_wave;

    // Decimation counter; the period limit is latched at each wrap so a SCAL
    // change never truncates the period in progress.
    always_ff @(posedge i_mtl_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_dc   <= 3'd0;
            r_scal <= 3'd0;
        end else if (i_sample_tr) begin
            if (r_dc == 3'd0) begin
                r_scal <= i_scal;
                r_dc   <= (i_scal == 3'd0) ? 3'd0 : 3'd1;
            end else if (r_dc == r_scal) begin
                r_dc <= 3'd0;
            end else begin
                r_dc <= r_dc + 3'd1;
            end
        end
    end

    // Capture state machine, write pointer, bank swap and trigger history.
    always_ff @(posedge i_mtl_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= ST_ARM;
            r_wa     <= '0;
            r_bank   <= 1'b0;
            r_fs_q   <= 1'b0;
            r_prev   <= '0;
            r_primed <= 1'b0;
        end else begin
            r_fs_q <= i_frame_sync;
            case (r_state)
                ST_ARM: begin
                    if (w_acc) begin
                        r_prev   <= w_ch0;
                        r_primed <= 1'b1;
                        if (w_we) begin
                            r_wa    <= r_wa + 1'b1;
                            r_state <= ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (w_acc) begin
                        r_wa <= r_wa + 1'b1;
                        if (r_wa == ADDR_W'(DEPTH - 1)) begin
                            r_state <= ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    // A strobe landing here is simply dropped; the swap wins.
                    if (w_fs_rise && i_start_stop) begin
                        r_bank   <= ~r_bank;
                        r_wa     <= '0;
                        r_primed <= 1'b0;
                        r_state  <= ST_ARM;
                    end
                end
                default: r_state <= ST_ARM;
            endcase
        end
    end

    wave_pingpong_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .i_clk   (i_mtl_clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr ({~r_bank, i_h_cnt[ADDR_W-1:0]}),
        .o_rdata (w_rdata)
    );

    // Display pipeline: align column-valid and row with RAM data, then keep the
    // previous and current trace heights so line mode can span the gap.
    always_ff @(posedge i_mtl_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_hv1 <= 1'b0;
            r_hv2 <= 1'b0;
            r_v1  <= '0;
            r_v2  <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_y_n[k]  <= '0;
                r_y_n1[k] <= '0;
            end
        end else begin
            r_hv1 <= (32'(i_h_cnt) < DEPTH);
            r_v1  <= i_v_cnt[8:0];
            r_hv2 <= r_hv1;
            r_v2  <= r_v1;
            for (int k = 0; k < NUM_CH; k++) begin
                r_y_n[k]  <= r_y_n1[k];
                r_y_n1[k] <= {~w_rdata[k*SAMPLE_W + SAMPLE_W - 1],
                              w_rdata[k*SAMPLE_W + SAMPLE_W - 2 -: 8]};
            end
        end
    end

    // Per-channel hit test for dot or line drawing on the current row.
    always_comb begin
        w_hit = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (i_draw_dot || (r_y_n[k] == r_y_n1[k])) begin
                w_hit[k] = (r_v2 == r_y_n[k]);
            end else if (r_y_n[k] < r_y_n1[k]) begin
                w_hit[k] = (r_v2 >= r_y_n[k]) && (r_v2 < r_y_n1[k]);
            end else begin
                w_hit[k] = (r_v2 >= r_y_n1[k]) && (r_v2 < r_y_n[k]);
            end
        end
    end

    // Colour select: lowest-index trace wins, then the centre row marker.
    always_comb begin
        w_pix = 24'h0;
        if (r_v2 == CENTRE_ROW) begin
            w_pix = i_start_stop ? GRID_COLOR : STOP_COLOR;
        end
        if (r_hv2) begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                if (w_hit[k]) begin
                    w_pix = ch_color(2'(k));
                end
            end
        end
    end

    // Registered pixel output.
    always_ff @(posedge i_mtl_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pix <= 24'h0;
        end else begin
            r_pix <= w_pix;
        end
    end

    // Upper row bits and low sample bits are not needed for drawing.
    assign w_unused = ^{i_v_cnt[11:9], w_rdata};

    assign o_pix_rgb    = r_pix;
    assign o_capt_state = r_state;
    assign o_bank_sel   = r_bank;

endmodule

// File: tb/tb_wave_scope_capture.sv
// Directed bench for wave_scope_capture with DEPTH=16, two channels.
module tb_wave_scope_capture;

    localparam int NUM_CH   = 2;
    localparam int SAMPLE_W = 16;
    localparam int DEPTH    = 16;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b1;
    logic        sample_tr  = 1'b0;
    logic [31:0] wave       = '0;
    logic [2:0]  scal       = '0;
    logic        start_stop = 1'b1;
    logic        trig_en    = 1'b0;
    logic signed [15:0] trig_level = '0;
    logic        frame_sync = 1'b0;
    logic        draw_dot   = 1'b0;
    logic [11:0] h_cnt      = '0;
    logic [11:0] v_cnt      = '0;
    logic [23:0] pix;
    logic [1:0]  st;
    logic        bank;

    int n_checks = 0;
    int n_fail   = 0;
    int n_wr     = 0;
    logic [3:0]  wr_addr [$];
    logic [15:0] wr_ch0  [$];

    always #5 clk = ~clk;

    wave_scope_capture #(
        .NUM_CH   (NUM_CH),
        .SAMPLE_W (SAMPLE_W),
        .DEPTH    (DEPTH)
    ) dut (
        .i_mtl_clk    (clk),
        .i_reset_n    (rst_n),
        .i_sample_tr  (sample_tr),
        .i_wave       (wave),
        .i_scal       (scal),
        .i_start_stop (start_stop),
        .i_trig_en    (trig_en),
        .i_trig_level (trig_level),
        .i_frame_sync (frame_sync),
        .i_draw_dot   (draw_dot),
        .i_h_cnt      (h_cnt),
        .i_v_cnt      (v_cnt),
        .o_pix_rgb    (pix),
        .o_capt_state (st),
        .o_bank_sel   (bank)
    );

    // Log every RAM write as seen on the write port.
    always @(posedge clk) begin
        if (dut.w_we) begin
            n_wr++;
            wr_addr.push_back(dut.w_waddr[3:0]);
            wr_ch0.push_back(dut.w_wdata[15:0]);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [15:0] ch0);
        wave      = {16'h8000, ch0};
        sample_tr = 1'b1;
        tick(1);
        sample_tr = 1'b0;
        tick(1);
    endtask

    task automatic pix_at(input string tag, input logic [11:0] v, input logic [23:0] exp);
        v_cnt = v;
        h_cnt = 12'd5;
        tick(1);
        h_cnt = 12'd6;
        tick(3);
        check(tag, pix, exp);
    endtask

    initial begin
        // Reset
        #1 rst_n = 1'b0;
        #2;
        check("rst_state", st, 2'd0);
        check("rst_bank", bank, 1'b0);
        check("rst_pix", pix, 24'h0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // Decimation: SCAL=3, 16 strobes -> writes at 0..3 from strobes 0,4,8,12
        scal = 3'd3;
        for (int i = 0; i < 16; i++) strobe(16'h8000 | 16'(i));
        check("dec_count", n_wr, 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("dec_addr%0d", k), (wr_addr.size() > k) ? wr_addr[k] : 4'hx, 4'(k));
            check($sformatf("dec_data%0d", k), (wr_ch0.size() > k) ? wr_ch0[k] : 16'hx, 16'h8000 | 16'(4*k));
        end
        check("dec_state", st, 2'd1);

        // Fill the rest of bank 0; addr5=0x0000, addr6=0x0100 for the pixel test
        scal = 3'd0;
        strobe(16'h8000);
        strobe(16'h0000);
        strobe(16'h0100);
        for (int j = 3; j < 11; j++) strobe(16'h8000);
        check("fill_state_cap", st, 2'd1);
        strobe(16'h8000);
        check("fill_state_full", st, 2'd2);
        check("fill_count", n_wr, 16);
        check("fill_last_addr", (wr_addr.size() > 15) ? wr_addr[15] : 4'hx, 4'd15);
        strobe(16'h1234);
        check("full_no_write", n_wr, 16);
        check("full_bank", bank, 1'b0);

        // Freeze across 3 frames
        start_stop = 1'b0;
        repeat (3) begin
            frame_sync = 1'b1;
            tick(2);
            frame_sync = 1'b0;
            tick(2);
        end
        check("frz_bank", bank, 1'b0);
        check("frz_state", st, 2'd2);
        h_cnt = 12'd20;
        v_cnt = 12'd255;
        tick(3);
        check("frz_centre", pix, 24'hFF0000);
        start_stop = 1'b1;
        tick(3);
        check("run_centre", pix, 24'h6F6F6F);
        v_cnt = 12'd100;
        tick(3);
        check("blank_pix", pix, 24'h0);

        // Swap on FRAME_SYNC rise with a coincident strobe (strobe dropped)
        frame_sync = 1'b1;
        wave       = {16'h8000, 16'h0055};
        sample_tr  = 1'b1;
        tick(1);
        sample_tr  = 1'b0;
        check("swap_bank", bank, 1'b1);
        check("swap_state", st, 2'd0);
        check("swap_no_write", n_wr, 16);
        tick(1);
        frame_sync = 1'b0;
        tick(1);
        check("swap_once_bank", bank, 1'b1);
        check("swap_once_state", st, 2'd0);

        // Trigger: first strobe only primes, then ramp -8,-4,0,4
        trig_en    = 1'b1;
        trig_level = 16'sd0;
        strobe(16'd4);
        strobe(16'hFFF8);
        strobe(16'hFFFC);
        check("trig_none", n_wr, 16);
        check("trig_arm", st, 2'd0);
        strobe(16'h0000);
        check("trig_count", n_wr, 17);
        check("trig_addr", (wr_addr.size() > 16) ? wr_addr[16] : 4'hx, 4'd0);
        check("trig_data", (wr_ch0.size() > 16) ? wr_ch0[16] : 16'hx, 16'h0000);
        check("trig_state", st, 2'd1);
        strobe(16'd4);
        check("trig_next_addr", (wr_addr.size() > 17) ? wr_addr[17] : 4'hx, 4'd1);

        // Pixels from bank 0: Y(5)=256, Y(6)=258
        draw_dot = 1'b0;
        pix_at("line_v256", 12'd256, 24'hFFFF00);
        pix_at("line_v257", 12'd257, 24'hFFFF00);
        pix_at("line_v258", 12'd258, 24'h0);
        pix_at("line_v255", 12'd255, 24'h6F6F6F);
        draw_dot = 1'b1;
        pix_at("dot_v256", 12'd256, 24'hFFFF00);
        pix_at("dot_v257", 12'd257, 24'h0);
        draw_dot = 1'b0;

        // Reset mid-capture at wa=7
        for (int i = 0; i < 5; i++) strobe(16'h0010);
        check("pre_rst_wa", dut.r_wa, 4'd7);
        check("pre_rst_state", st, 2'd1);
        h_cnt = 12'd20;
        v_cnt = 12'd255;
        tick(3);
        check("pre_rst_pix", pix, 24'h6F6F6F);
        rst_n = 1'b0;
        #2;
        check("mid_rst_state", st, 2'd0);
        check("mid_rst_wa", dut.r_wa, 4'd0);
        check("mid_rst_pix", pix, 24'h0);
        check("mid_rst_bank", bank, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
